id_ex_stage: RTL and testbench

ID/EX pipeline register and hazard unit for the MIPS16 core. It consumes the decoder's per-instruction control word and register selectors, then registers them into the EX stage. It detects load-use hazards, stalls fetch/decode for one cycle, and inserts a bubble. It also computes registered forwarding selects for both ALU operands and drops the ID instruction on a taken branch or jump.

---
 rtl/id_ex_stage.sv | 155 +++++++++++++++
 tb/tb_id_ex_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, one-cycle stall,
// bubble insertion, branch/jump flush and registered operand forwarding selects.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        flush,
    input  logic        alu_src,
    input  logic        mem_to_reg,
    input  logic        reg_write,
    input  logic        mem_write,
    input  logic        jump,
    input  logic        mem_read,
    input  logic [1:0]  branch,
    input  logic [3:0]  alu_op,
    input  logic [2:0]  src_get,
    input  logic [3:0]  reg_out1,
    input  logic [3:0]  reg_out2,
    input  logic [3:0]  reg_out3,
    input  logic [15:0] rd1,
    input  logic [15:0] rd2,
    input  logic [15:0] imm,
    input  logic [15:0] pc,
    input  logic [3:0]  mem_dest,
    input  logic        mem_reg_write,
    output logic        ex_alu_src,
    output logic        ex_mem_to_reg,
    output logic        ex_reg_write,
    output logic        ex_mem_write,
    output logic        ex_jump,
    output logic        ex_mem_read,
    output logic [1:0]  ex_branch,
    output logic [3:0]  ex_alu_op,
    output logic [2:0]  ex_src_get,
    output logic [3:0]  ex_reg_out1,
    output logic [3:0]  ex_reg_out2,
    output logic [3:0]  ex_reg_out3,
    output logic [15:0] ex_rd1,
    output logic [15:0] ex_rd2,
    output logic [15:0] ex_imm,
    output logic [15:0] ex_pc,
    output logic        ex_valid,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        stall,
    output logic [15:0] stall_count
);

    // Encodings mirror config.v of the MIPS16 core.
    localparam logic [3:0] REG0      = 4'hF;
    localparam logic [1:0] NB        = 2'b00;
    localparam logic [3:0] NO_ALU_OP = 4'hF;

    typedef enum logic {RUN, HOLD} state_t;

    state_t     state, state_next;
    logic       hazard;
    logic       load_bubble;
    logic [1:0] fwd_a_next, fwd_b_next;

    function automatic logic src_match(input logic [3:0] src, input logic [3:0] dest,
                                       input logic we);
        return we && (src != REG0) && (src == dest);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [3:0] src, input logic [3:0] ex_dest,
                                           input logic ex_we, input logic ex_load,
                                           input logic [3:0] m_dest, input logic m_we);
        if (src_match(src, ex_dest, ex_we) && !ex_load)
            return 2'b01;
        else if (src_match(src, m_dest, m_we))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        hazard      = 1'b0;
        stall       = 1'b0;
        state_next  = RUN;
        load_bubble = 1'b0;
        fwd_a_next  = 2'b00;
        fwd_b_next  = 2'b00;

        hazard = (state == RUN) && id_valid && ex_valid && ex_mem_read &&
                 (src_match(reg_out1, ex_reg_out3, ex_reg_write) ||
                  src_match(reg_out2, ex_reg_out3, ex_reg_write));
        stall = rst && hazard && !flush;

        if (!flush && stall)
            state_next = HOLD;

        load_bubble = flush || stall || !id_valid;
        if (!load_bubble) begin
            fwd_a_next = fwd_sel(reg_out1, ex_reg_out3, ex_reg_write, ex_mem_read,
                                 mem_dest, mem_reg_write);
            fwd_b_next = fwd_sel(reg_out2, ex_reg_out3, ex_reg_write, ex_mem_read,
                                 mem_dest, mem_reg_write);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            stall_count <= '0;
        end else begin
            state <= state_next;
            if (stall && stall_count != '1)
                stall_count <= stall_count + 16'd1;
        end

        if (!rst || load_bubble) begin
            ex_valid      <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_jump       <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_branch     <= NB;
            ex_alu_op     <= NO_ALU_OP;
            ex_src_get    <= '0;
            ex_reg_out1   <= REG0;
            ex_reg_out2   <= REG0;
            ex_reg_out3   <= REG0;
            ex_rd1        <= '0;
            ex_rd2        <= '0;
            ex_imm        <= '0;
            ex_pc         <= '0;
            fwd_a         <= 2'b00;
            fwd_b         <= 2'b00;
        end else begin
            ex_valid      <= 1'b1;
            ex_alu_src    <= alu_src;
            ex_mem_to_reg <= mem_to_reg;
            ex_reg_write  <= reg_write;
            ex_mem_write  <= mem_write;
            ex_jump       <= jump;
            ex_mem_read   <= mem_read;
            ex_branch     <= branch;
            ex_alu_op     <= alu_op;
            ex_src_get    <= src_get;
            ex_reg_out1   <= reg_out1;
            ex_reg_out2   <= reg_out2;
            ex_reg_out3   <= reg_out3;
            ex_rd1        <= rd1;
            ex_rd2        <= rd2;
            ex_imm        <= imm;
            ex_pc         <= pc;
            fwd_a         <= fwd_a_next;
            fwd_b         <= fwd_b_next;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, pass-through, forwarding,
// load-use stall, flush priority, REG0 immunity, back-to-back loads, saturation.
module tb_id_ex_stage;

    localparam logic [3:0] REG0      = 4'hF;
    localparam logic [1:0] NB        = 2'b00;
    localparam logic [3:0] NO_ALU_OP = 4'hF;

    logic        clk = 1'b0;
    logic        rst, id_valid, flush;
    logic        alu_src, mem_to_reg, reg_write, mem_write, jump, mem_read;
    logic [1:0]  branch;
    logic [3:0]  alu_op;
    logic [2:0]  src_get;
    logic [3:0]  reg_out1, reg_out2, reg_out3;
    logic [15:0] rd1, rd2, imm, pc;
    logic [3:0]  mem_dest;
    logic        mem_reg_write;
    logic        ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_write, ex_jump, ex_mem_read;
    logic [1:0]  ex_branch;
    logic [3:0]  ex_alu_op;
    logic [2:0]  ex_src_get;
    logic [3:0]  ex_reg_out1, ex_reg_out2, ex_reg_out3;
    logic [15:0] ex_rd1, ex_rd2, ex_imm, ex_pc;
    logic        ex_valid;
    logic [1:0]  fwd_a, fwd_b;
    logic        stall;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_count = 16'd0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush),
        .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .mem_write(mem_write), .jump(jump), .mem_read(mem_read),
        .branch(branch), .alu_op(alu_op), .src_get(src_get),
        .reg_out1(reg_out1), .reg_out2(reg_out2), .reg_out3(reg_out3),
        .rd1(rd1), .rd2(rd2), .imm(imm), .pc(pc),
        .mem_dest(mem_dest), .mem_reg_write(mem_reg_write),
        .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_write(ex_mem_write), .ex_jump(ex_jump), .ex_mem_read(ex_mem_read),
        .ex_branch(ex_branch), .ex_alu_op(ex_alu_op), .ex_src_get(ex_src_get),
        .ex_reg_out1(ex_reg_out1), .ex_reg_out2(ex_reg_out2), .ex_reg_out3(ex_reg_out3),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_valid(ex_valid), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall(stall), .stall_count(stall_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b1; id_valid = 1'b0; flush = 1'b0;
        alu_src = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0; mem_write = 1'b0;
        jump = 1'b0; mem_read = 1'b0; branch = NB; alu_op = NO_ALU_OP; src_get = 3'd0;
        reg_out1 = REG0; reg_out2 = REG0; reg_out3 = REG0;
        rd1 = 16'd0; rd2 = 16'd0; imm = 16'd0; pc = 16'd0;
        mem_dest = REG0; mem_reg_write = 1'b0;
    endtask

    task automatic instr(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                         input logic rw, input logic mr);
        id_valid = 1'b1; reg_out1 = a; reg_out2 = b; reg_out3 = d;
        reg_write = rw; mem_read = mr; mem_to_reg = mr; alu_op = 4'd1;
        rd1 = 16'h1234; rd2 = 16'h5678; imm = 16'h0042; pc = 16'h0100;
    endtask

    task automatic test_reset();
        rst = 1'b0; id_valid = 1'b1; flush = 1'b0;
        alu_src = 1'b1; reg_write = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1;
        branch = 2'($urandom_range(1, 3)); alu_op = 4'($urandom_range(0, 14));
        reg_out1 = 4'($urandom_range(0, 7)); reg_out2 = 4'($urandom_range(0, 7));
        reg_out3 = 4'($urandom_range(0, 7)); rd1 = 16'($urandom); pc = 16'($urandom);
        tick();
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %b want 0", ex_valid); end
        checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write got %b want 0", ex_reg_write); end
        checks++; if (ex_branch !== NB) begin errors++; $display("FAIL reset_branch got %b want %b", ex_branch, NB); end
        checks++; if (ex_alu_op !== NO_ALU_OP) begin errors++; $display("FAIL reset_alu_op got %h want %h", ex_alu_op, NO_ALU_OP); end
        checks++; if (ex_reg_out3 !== REG0 || ex_rd1 !== 16'd0) begin errors++; $display("FAIL reset_fields got %h/%h want %h/0", ex_reg_out3, ex_rd1, REG0); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_count got %h want 0", stall_count); end
        checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL reset_fwd got %b/%b want 00/00", fwd_a, fwd_b); end
        clear_inputs();
        tick();
    endtask

    task automatic test_pass_through();
        instr(4'd1, 4'd2, 4'd3, 1'b1, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL pass_stall got %b want 0", stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_reg_out3 !== 4'd3) begin errors++; $display("FAIL pass_load got v=%b d=%h want v=1 d=3", ex_valid, ex_reg_out3); end
        checks++; if (ex_rd1 !== 16'h1234 || ex_pc !== 16'h0100 || ex_reg_write !== 1'b1) begin errors++; $display("FAIL pass_data got %h %h %b want 1234 0100 1", ex_rd1, ex_pc, ex_reg_write); end
        checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL pass_fwd got %b/%b want 00/00", fwd_a, fwd_b); end
        clear_inputs();
        tick();
    endtask

    task automatic test_alu_forward();
        instr(4'd5, REG0, 4'd1, 1'b1, 1'b0);
        tick();
        // EX writer to r1 and MEM/WB writer to r1 together: EX/MEM must win
        instr(4'd1, 4'd2, 4'd6, 1'b1, 1'b0);
        mem_dest = 4'd1; mem_reg_write = 1'b1;
        tick();
        checks++; if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_exmem got %b/%b want 01/00", fwd_a, fwd_b); end
        clear_inputs();
        tick();
        instr(4'd5, REG0, 4'd1, 1'b1, 1'b0);
        tick();
        clear_inputs();
        tick();
        instr(4'd2, 4'd1, 4'd6, 1'b1, 1'b0);
        mem_dest = 4'd1; mem_reg_write = 1'b1;
        tick();
        checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b10) begin errors++; $display("FAIL fwd_memwb got %b/%b want 00/10", fwd_a, fwd_b); end
        clear_inputs();
        tick();
    endtask

    task automatic test_load_use();
        instr(4'd5, REG0, 4'd4, 1'b1, 1'b1);
        tick();
        instr(4'd2, 4'd4, 4'd7, 1'b1, 1'b0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall); end
        tick();
        exp_count = exp_count + 16'd1;
        checks++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0) begin errors++; $display("FAIL lu_bubble got v=%b mr=%b want 0/0", ex_valid, ex_mem_read); end
        checks++; if (stall_count !== exp_count) begin errors++; $display("FAIL lu_count got %h want %h", stall_count, exp_count); end
        mem_dest = 4'd4; mem_reg_write = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_hold_stall got %b want 0", stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_reg_out3 !== 4'd7) begin errors++; $display("FAIL lu_reload got v=%b d=%h want 1/7", ex_valid, ex_reg_out3); end
        checks++; if (fwd_b !== 2'b10 || fwd_a !== 2'b00) begin errors++; $display("FAIL lu_fwd got %b/%b want 00/10", fwd_a, fwd_b); end
        clear_inputs();
        tick();
    endtask

    task automatic test_flush();
        instr(4'd5, REG0, 4'd4, 1'b1, 1'b1);
        tick();
        instr(4'd4, 4'd2, 4'd7, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %b want 0", stall); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin errors++; $display("FAIL fl_bubble got v=%b rw=%b want 0/0", ex_valid, ex_reg_write); end
        checks++; if (stall_count !== exp_count) begin errors++; $display("FAIL fl_count got %h want %h", stall_count, exp_count); end
        flush = 1'b0;
        instr(4'd1, 4'd2, 4'd3, 1'b1, 1'b0);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_reg_out3 !== 4'd3) begin errors++; $display("FAIL fl_next got v=%b d=%h want 1/3", ex_valid, ex_reg_out3); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reg0();
        instr(4'd5, REG0, REG0, 1'b1, 1'b1);
        tick();
        instr(REG0, REG0, 4'd3, 1'b1, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reg0_stall got %b want 0", stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL reg0_fwd got v=%b %b/%b want 1 00/00", ex_valid, fwd_a, fwd_b); end
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        instr(4'd5, REG0, 4'd4, 1'b1, 1'b1);
        tick();
        instr(4'd4, REG0, 4'd4, 1'b1, 1'b1);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall got %b want 1", stall); end
        tick();
        exp_count = exp_count + 16'd1;
        mem_dest = 4'd4; mem_reg_write = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_mem_read !== 1'b1 || fwd_a !== 2'b10) begin errors++; $display("FAIL b2b_load got v=%b mr=%b fa=%b want 1 1 10", ex_valid, ex_mem_read, fwd_a); end
        mem_dest = REG0; mem_reg_write = 1'b0;
        instr(4'd1, 4'd2, 4'd3, 1'b1, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_indep got %b want 0", stall); end
        tick();
        checks++; if (stall_count !== exp_count) begin errors++; $display("FAIL b2b_count got %h want %h", stall_count, exp_count); end
        clear_inputs();
        tick();
    endtask

    task automatic test_saturation();
        for (int unsigned n = 0; n < 2; n++) begin
            if (n == 0) begin
                force dut.stall_count = 16'hFFFE;
                #1;
                release dut.stall_count;
            end
            instr(4'd5, REG0, 4'd4, 1'b1, 1'b1);
            tick();
            instr(4'd2, 4'd4, 4'd7, 1'b1, 1'b0);
            #1;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall%0d got %b want 1", n, stall); end
            tick();
            checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count%0d got %h want ffff", n, stall_count); end
            mem_dest = 4'd4; mem_reg_write = 1'b1;
            tick();
            clear_inputs();
            tick();
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_pass_through();
        test_alu_forward();
        test_load_use();
        test_flush();
        test_reg0();
        test_back_to_back();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
